// File: rtl/timer_setter.sv
// Time-entry controller: edits hours/minutes/seconds with wrap-around and pulses start_o on confirm.
// Optional hold-to-repeat stepping is enabled by defining AUTO_REPEAT_EN.
module timer_setter #(
  parameter int HOURS_MAX   = 23,
  parameter int REPEAT_DLY  = 16,
  parameter int REPEAT_RATE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       dec_btn,
  input  logic       confirm_btn,
  output logic [4:0] hours_o,
  output logic [5:0] mins_o,
  output logic [5:0] secs_o,
  output logic       start_o,
  output logic [1:0] field_o
);

  typedef enum logic [2:0] {IDLE, SET_H, SET_M, SET_S, LOAD} state_t;

  state_t     state;
  logic [3:0] btn_q;
  logic       mode_ev, inc_ev, dec_ev, confirm_ev;
  logic       in_set, nonzero, commit, advance, edit;
  logic       step_up, step_dn;
  logic [4:0] hours_nxt;
  logic [5:0] mins_nxt, secs_nxt;

  function automatic logic [5:0] bump(input logic [5:0] v, input logic [5:0] max,
                                      input logic up, input logic dn);
    if (up)      return (v == max) ? 6'd0 : v + 6'd1;
    else if (dn) return (v == 6'd0) ? max : v - 6'd1;
    else         return v;
  endfunction

  assign mode_ev    = mode_btn    & ~btn_q[3];
  assign inc_ev     = inc_btn     & ~btn_q[2];
  assign dec_ev     = dec_btn     & ~btn_q[1];
  assign confirm_ev = confirm_btn & ~btn_q[0];

  assign in_set  = (state == SET_H) || (state == SET_M) || (state == SET_S);
  assign nonzero = |{hours_o, mins_o, secs_o};
  // Priority confirm > mode > inc/dec; a rejected confirm still swallows lower events.
  assign commit  = in_set & confirm_ev & nonzero;
  assign advance = in_set & ~confirm_ev & mode_ev;
  assign edit    = in_set & ~confirm_ev & ~mode_ev;

`ifdef AUTO_REPEAT_EN
  localparam int CNT_W = $clog2(REPEAT_DLY + 1) + 1;
  localparam logic [CNT_W-1:0] DLY_C    = CNT_W'(REPEAT_DLY);
  localparam logic [CNT_W-1:0] RELOAD_C = CNT_W'(REPEAT_DLY - REPEAT_RATE + 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             hold, rpt;

  assign hold = in_set & (inc_btn ^ dec_btn) & ~commit & ~advance;
  assign rpt  = hold & (hold_cnt == DLY_C);

  // Reloading just short of the delay makes every later repeat fire REPEAT_RATE cycles apart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           hold_cnt <= '0;
    else if (!hold)       hold_cnt <= '0;
    else if (rpt)         hold_cnt <= RELOAD_C;
    else                  hold_cnt <= hold_cnt + 1'b1;
  end

  assign step_up = edit & ((inc_ev & ~dec_ev) | (rpt & inc_btn));
  assign step_dn = edit & ((dec_ev & ~inc_ev) | (rpt & dec_btn));
`else
  logic repeat_unused;
  assign repeat_unused = (REPEAT_DLY != 0) ^ (REPEAT_RATE != 0);

  assign step_up = edit & inc_ev & ~dec_ev;
  assign step_dn = edit & dec_ev & ~inc_ev;
`endif

  // Unselected fields fall through bump() unchanged.
  assign hours_nxt = 5'(bump({1'b0, hours_o}, 6'(HOURS_MAX),
                             step_up & (state == SET_H), step_dn & (state == SET_H)));
  assign mins_nxt  = bump(mins_o, 6'd59, step_up & (state == SET_M), step_dn & (state == SET_M));
  assign secs_nxt  = bump(secs_o, 6'd59, step_up & (state == SET_S), step_dn & (state == SET_S));

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      btn_q   <= '0;
      hours_o <= '0;
      mins_o  <= '0;
      secs_o  <= '0;
      start_o <= 1'b0;
      field_o <= 2'd0;
    end else begin
      btn_q   <= {mode_btn, inc_btn, dec_btn, confirm_btn};
      hours_o <= hours_nxt;
      mins_o  <= mins_nxt;
      secs_o  <= secs_nxt;
      case (state)
        IDLE: begin
          start_o <= 1'b0;
          if (mode_ev) begin
            state   <= SET_H;
            field_o <= 2'd1;
          end
        end
        SET_H, SET_M, SET_S: begin
          if (commit) begin
            state   <= LOAD;
            start_o <= 1'b1;
            field_o <= 2'd0;
          end else if (advance) begin
            case (state)
              SET_H:   begin state <= SET_M; field_o <= 2'd2; end
              SET_M:   begin state <= SET_S; field_o <= 2'd3; end
              default: begin state <= SET_H; field_o <= 2'd1; end
            endcase
          end
        end
        default: begin
          state   <= IDLE;
          start_o <= 1'b0;
          field_o <= 2'd0;
        end
      endcase
    end
  end

endmodule
